// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_seq_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NR_128  = 10;
    localparam int RK_IDX_W    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        LAST  = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Round-key index for the current step. Decrypt walks the schedule backwards.
    function automatic logic [RK_IDX_W-1:0] key_index(
        input seq_state_t          st,
        input logic                enc,
        input logic [RK_IDX_W-1:0] rnd,
        input logic [RK_IDX_W-1:0] nr
    );
        logic [RK_IDX_W-1:0] idx;
        idx = '0;
        case (st)
            INIT:    idx = enc ? '0  : nr;
            ROUND:   idx = enc ? rnd : nr - rnd;
            LAST:    idx = enc ? nr  : '0;
            default: idx = '0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/aes_seq_outbuf.sv
// One-entry valid/ready register slice holding a finished block so the
// sequencer can start the next one while the consumer stalls.
module aes_seq_outbuf
    import aes_seq_pkg::*;
#(
    parameter int W = AES_BLOCK_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    // A full entry that is being drained this cycle can be refilled at once.
    assign o_ready = ~r_full | i_ready;
    assign o_valid = r_full;
    assign o_data  = r_data;

    // Capture on load, release on consumer acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && o_ready) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_ready) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES block controller: key whitening, NR-1 full rounds, one last
// round, using an external combinational round datapath and key store.
// Optional feature macro: AES_SEQ_OUTBUF_EN (adds a one-entry output buffer so
// the next block can start while a result waits for the consumer).
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int NR      = AES_NR_128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic                i_in_encrypt,
    input  logic [BLOCK_W-1:0]  i_in_data,
    output logic [RK_IDX_W-1:0] o_rk_idx,
    input  logic [BLOCK_W-1:0]  i_rk_data,
    output logic [BLOCK_W-1:0]  o_rd_data,
    output logic                o_rd_encrypt,
    output logic                o_rd_last,
    input  logic [BLOCK_W-1:0]  i_rd_result,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [BLOCK_W-1:0]  o_out_data,
    output logic                o_busy
);

    localparam logic [RK_IDX_W-1:0] LP_NR    = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] LP_NR_M1 = RK_IDX_W'(NR - 1);

    seq_state_t          r_fsm, w_fsm_next;
    logic [BLOCK_W-1:0]  r_blk, w_blk_next;
    logic [RK_IDX_W-1:0] r_rnd, w_rnd_next;
    logic                r_dir, w_dir_next;

`ifdef AES_SEQ_OUTBUF_EN
    logic                w_ob_ready;
    logic                w_ob_load;
    logic [BLOCK_W-1:0]  w_ob_data;
`else
    logic                w_out_valid;
`endif

    // State, counter and direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
            r_blk <= '0;
            r_rnd <= '0;
            r_dir <= 1'b0;
        end else begin
            r_fsm <= w_fsm_next;
            r_blk <= w_blk_next;
            r_rnd <= w_rnd_next;
            r_dir <= w_dir_next;
        end
    end

    // Next-state, datapath select and handshake outputs.
    always_comb begin
        w_fsm_next = r_fsm;
        w_blk_next = r_blk;
        w_rnd_next = r_rnd;
        w_dir_next = r_dir;
        o_in_ready = 1'b0;
        o_rd_last  = 1'b0;
`ifdef AES_SEQ_OUTBUF_EN
        w_ob_load  = 1'b0;
`else
        w_out_valid = 1'b0;
`endif
        case (r_fsm)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_blk_next = i_in_data;
                    w_dir_next = i_in_encrypt;
                    w_fsm_next = INIT;
                end
            end
            INIT: begin
                w_blk_next = r_blk ^ i_rk_data;
                w_rnd_next = RK_IDX_W'(1);
                w_fsm_next = ROUND;
            end
            ROUND: begin
                w_blk_next = i_rd_result;
                w_rnd_next = r_rnd + RK_IDX_W'(1);
                if (r_rnd == LP_NR_M1) begin
                    w_fsm_next = LAST;
                end
            end
            LAST: begin
                o_rd_last  = 1'b1;
                w_blk_next = i_rd_result;
`ifdef AES_SEQ_OUTBUF_EN
                // Hand the result straight to the buffer when it has room.
                if (w_ob_ready) begin
                    w_ob_load  = 1'b1;
                    w_fsm_next = IDLE;
                end else begin
                    w_fsm_next = DONE;
                end
`else
                w_fsm_next = DONE;
`endif
            end
            DONE: begin
`ifdef AES_SEQ_OUTBUF_EN
                // Waiting for the buffer to drain before parking the result.
                if (w_ob_ready) begin
                    w_ob_load  = 1'b1;
                    w_fsm_next = IDLE;
                end
`else
                w_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_fsm_next = IDLE;
                end
`endif
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    assign o_rk_idx     = key_index(r_fsm, r_dir, r_rnd, LP_NR);
    assign o_rd_data    = r_blk;
    assign o_rd_encrypt = r_dir;
    assign o_busy       = (r_fsm != IDLE);

`ifdef AES_SEQ_OUTBUF_EN
    // In LAST the result is still on the datapath; in DONE it is in r_blk.
    assign w_ob_data = (r_fsm == LAST) ? i_rd_result : r_blk;

    aes_seq_outbuf #(.W(BLOCK_W)) u_outbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_ob_load),
        .o_ready (w_ob_ready),
        .i_data  (w_ob_data),
        .o_valid (o_out_valid),
        .i_ready (i_out_ready),
        .o_data  (o_out_data)
    );
`else
    assign o_out_valid = w_out_valid;
    assign o_out_data  = r_blk;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer with a behavioural AES-128 round datapath and
// key store (key 000102..0f). Honours AES_SEQ_OUTBUF_EN for throughput rules.
module tb_aes_round_sequencer;
    import aes_seq_pkg::*;

    localparam int W       = 128;
    localparam int NR      = 10;
    localparam int LAT_EXP = NR + 2;
`ifdef AES_SEQ_OUTBUF_EN
    localparam int PER_EXP = NR + 2;
`else
    localparam int PER_EXP = NR + 3;
`endif
    localparam logic [W-1:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_encrypt = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, rd_encrypt, rd_last, out_valid, busy;
    logic [3:0]   rk_idx;
    logic [W-1:0] rk_data, rd_data, rd_result, out_data;

    always #5 clk = ~clk;

    aes_round_sequencer #(.BLOCK_W(W), .NR(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_encrypt(in_encrypt), .i_in_data(in_data),
        .o_rk_idx(rk_idx), .i_rk_data(rk_data),
        .o_rd_data(rd_data), .o_rd_encrypt(rd_encrypt), .o_rd_last(rd_last), .i_rd_result(rd_result),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data), .o_busy(busy)
    );

    // ---------------- AES reference pieces ----------------
    logic [7:0]   sbox_t [256];
    logic [7:0]   isbox_t [256];
    logic [W-1:0] rk_tbl [11];
    logic [31:0]  kw [44];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0; x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [W-1:0] aes_round(input logic [W-1:0] s, input logic [W-1:0] k,
                                              input logic enc, input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] cf [4];
        logic [W-1:0] r;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        if (enc) begin
            cf[0] = 8'd2; cf[1] = 8'd3; cf[2] = 8'd1; cf[3] = 8'd1;
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) b[rr+4*c] = sbox_t[a[rr+4*((c+rr)%4)]];
        end else begin
            cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) b[rr+4*c] = isbox_t[a[rr+4*((c-rr+4)%4)]];
            for (int i = 0; i < 16; i++) b[i] ^= k[127-8*i -: 8];
        end
        if (!last) begin
            for (int i = 0; i < 16; i++) a[i] = b[i];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) begin
                    b[4*c+rr] = '0;
                    for (int j = 0; j < 4; j++) b[4*c+rr] ^= gmul(a[4*c+j], cf[(j-rr+4)%4]);
                end
        end
        if (enc) for (int i = 0; i < 16; i++) b[i] ^= k[127-8*i -: 8];
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    function automatic logic [W-1:0] ref_aes(input logic [W-1:0] d, input logic enc);
        logic [W-1:0] s;
        if (enc) begin
            s = d ^ rk_tbl[0];
            for (int r = 1; r < NR; r++) s = aes_round(s, rk_tbl[r], 1'b1, 1'b0);
            s = aes_round(s, rk_tbl[NR], 1'b1, 1'b1);
        end else begin
            s = d ^ rk_tbl[NR];
            for (int r = NR - 1; r >= 1; r--) s = aes_round(s, rk_tbl[r], 1'b0, 1'b0);
            s = aes_round(s, rk_tbl[0], 1'b0, 1'b1);
        end
        return s;
    endfunction

    // External key store and round datapath, both combinational.
    always_comb rk_data = (rk_idx <= 4'd10) ? rk_tbl[rk_idx] : '0;
    always_comb rd_result = aes_round(rd_data, rk_data, rd_encrypt, rd_last);

    // ---------------- scoreboard / monitor ----------------
    int checks = 0, failures = 0;
    int cyc = 0, n_acc = 0, n_out = 0, fv_cyc = 0, cap_left = 0;
    logic [W-1:0] sb_q [$];
    int           acc_q [$];
    int           acc_log [$];
    logic [3:0]   rk_log [$];
    logic         last_log [$];
    logic [W-1:0] cur_exp = '0, prev_od = '0, exp_v;
    logic         prev_ov = 1'b0, prev_hs = 1'b0, prev_hold = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0; prev_hs = 1'b0; prev_hold = 1'b0; cap_left = 0;
        end else begin
            cyc++;
            if (in_valid && in_ready) begin
                sb_q.push_back(cur_exp); acc_q.push_back(cyc); acc_log.push_back(cyc);
                n_acc++; cap_left = NR + 1; rk_log.delete(); last_log.delete();
            end else if (cap_left > 0) begin
                rk_log.push_back(rk_idx); last_log.push_back(rd_last); cap_left--;
            end
            if (out_valid && (!prev_ov || prev_hs)) fv_cyc = cyc;
            if (prev_hold) begin
                checks++;
                if (!out_valid || out_data !== prev_od) begin
                    failures++;
                    $display("FAIL hold_stable: valid=%b data=%h want valid=1 data=%h", out_valid, out_data, prev_od);
                end
            end
`ifndef AES_SEQ_OUTBUF_EN
            checks++;
            if (in_ready && out_valid) begin
                failures++;
                $display("FAIL ready_valid_excl: in_ready=1 out_valid=1 at cycle %0d, want not both", cyc);
            end
`endif
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out: got %h with empty scoreboard", out_data);
                end else begin
                    exp_v = sb_q.pop_front();
                    if (out_data !== exp_v) begin
                        failures++;
                        $display("FAIL out_data: got %h want %h", out_data, exp_v);
                    end
                    checks++;
                    if (fv_cyc - acc_q[0] != LAT_EXP) begin
                        failures++;
                        $display("FAIL latency: got %0d want %0d", fv_cyc - acc_q[0], LAT_EXP);
                    end
                    void'(acc_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_hs   = out_valid && out_ready;
            prev_od   = out_data;
            prev_ov   = out_valid;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present one block and hold it until the sequencer takes it.
    task automatic send(input logic enc, input logic [W-1:0] d, input logic [W-1:0] e);
        int n0;
        n0 = n_acc;
        in_valid = 1'b1; in_encrypt = enc; in_data = d; cur_exp = e;
        for (int i = 0; i < 60 && n_acc == n0; i++) tick(1);
        chk("accept_timeout", W'(n_acc != n0), W'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) tick(1);
        chk("drain_timeout", W'(sb_q.size()), W'(0));
    endtask

    typedef struct {
        logic         enc;
        logic [W-1:0] din;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vt [5];

    initial begin
        logic [7:0] inv, sv, rc;
        logic [31:0] t;
        int n0, a0;
        // S-box tables from GF(2^8) inversion plus the affine map.
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
            sv = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                     ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = sv;
            isbox_t[sv] = 8'(x);
        end
        // AES-128 key schedule.
        for (int i = 0; i < 4; i++) kw[i] = KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = kw[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            kw[i] = kw[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk_tbl[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};

        vt[0] = '{1'b1, PT, CT};
        vt[1] = '{1'b0, CT, PT};
        vt[2] = '{1'b1, {W{1'b1}}, ref_aes({W{1'b1}}, 1'b1)};
        vt[3] = '{1'b0, '0, ref_aes('0, 1'b0)};
        vt[4] = '{1'b1, 128'h0123456789abcdeffedcba9876543210,
                  ref_aes(128'h0123456789abcdeffedcba9876543210, 1'b1)};

        // Reset values.
        tick(2);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_rk_idx", W'(rk_idx), W'(0));
        chk("rst_rd_data", rd_data, '0);
        chk("rst_rd_last", W'(rd_last), W'(0));
        chk("rst_rd_encrypt", W'(rd_encrypt), W'(0));
        chk("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(2);

        // Table vectors: result, latency, key-index order and last-round flag.
        for (int v = 0; v < 5; v++) begin
            send(vt[v].enc, vt[v].din, vt[v].exp);
            drain(40);
            chk("rk_log_len", W'(rk_log.size()), W'(NR + 1));
            for (int j = 0; j < rk_log.size() && j <= NR; j++) begin
                chk($sformatf("rk_idx[v%0d j%0d]", v, j), W'(rk_log[j]), W'(vt[v].enc ? j : NR - j));
                chk($sformatf("rd_last[v%0d j%0d]", v, j), W'(last_log[j]), W'(j == NR));
            end
            chk("idle_after_out", W'(in_ready), W'(1));
        end

        // Consumer stall: result must be held for 20 cycles.
        out_ready = 1'b0;
        send(1'b1, vt[4].din, vt[4].exp);
        for (int i = 0; i < 30 && !out_valid; i++) tick(1);
        chk("stall_valid_seen", W'(out_valid), W'(1));
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("stall_out_valid", W'(out_valid), W'(1));
`ifndef AES_SEQ_OUTBUF_EN
            chk("stall_in_ready", W'(in_ready), W'(0));
`endif
        end
        out_ready = 1'b1;
        tick(1);
        chk("release_in_ready", W'(in_ready), W'(1));
        chk("release_busy", W'(busy), W'(0));
        chk("release_out_valid", W'(out_valid), W'(0));
        chk("release_sb_empty", W'(sb_q.size()), W'(0));

        // Three blocks back-to-back with in_valid held high.
        n0 = n_acc; a0 = acc_log.size(); in_valid = 1'b1;
        in_encrypt = vt[0].enc; in_data = vt[0].din; cur_exp = vt[0].exp;
        for (int i = 0; i < 100 && n_acc - n0 < 3; i++) begin
            tick(1);
            if (n_acc - n0 == 1) begin in_encrypt = vt[2].enc; in_data = vt[2].din; cur_exp = vt[2].exp; end
            if (n_acc - n0 == 2) begin in_encrypt = vt[1].enc; in_data = vt[1].din; cur_exp = vt[1].exp; end
        end
        in_valid = 1'b0;
        drain(40);
        chk("stream_accepts", W'(n_acc - n0), W'(3));
        if (acc_log.size() >= a0 + 3) begin
            chk("stream_period_1", W'(acc_log[a0+1] - acc_log[a0]), W'(PER_EXP));
            chk("stream_period_2", W'(acc_log[a0+2] - acc_log[a0+1]), W'(PER_EXP));
        end

        // Reset in the middle of ROUND (rnd=5).
        n0 = n_out;
        send(1'b1, vt[0].din, vt[0].exp);
        tick(5);
        chk("pre_reset_rk_idx", W'(rk_idx), W'(5));
        chk("pre_reset_busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_rk_idx", W'(rk_idx), W'(0));
        chk("mid_rst_rd_data", rd_data, '0);
        chk("mid_rst_out_data", out_data, '0);
        sb_q.delete(); acc_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("no_out_after_reset", W'(n_out - n0), W'(0));
        send(vt[1].enc, vt[1].din, vt[1].exp);
        drain(40);

        // Direction and data wiggled after acceptance must be ignored.
        send(1'b0, CT, PT);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            in_encrypt = ~in_encrypt;
            in_data = ~in_data;
            tick(1);
            if (busy) chk("latched_dir", W'(rd_encrypt), W'(0));
        end
        drain(5);

        chk("final_sb_empty", W'(sb_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
